// File: rtl/cpu_loader_pkg.sv
// ---------------------------------------------------------------------------
// cpu_loader_pkg
//   Shared types and helpers for the UART program loader.
//   - loader_state_t    : load phase (data words, instruction words, done)
//   - DELIMITER_DEFAULT : fill bit replicated to the word width to form the
//                         default phase-switch word (all ones)
//   - byte_idx_w()      : width of the byte-within-word counter
// ---------------------------------------------------------------------------
package cpu_loader_pkg;

    typedef enum logic [1:0] {
        S_DATA = 2'd0,
        S_INST = 2'd1,
        S_DONE = 2'd2
    } loader_state_t;

    localparam logic DELIMITER_DEFAULT = 1'b1;

    // A one-byte word still needs a 1-bit counter to stay a legal vector.
    function automatic int unsigned byte_idx_w(input int unsigned word_bytes);
        if (word_bytes <= 1)
            return 1;
        else
            return int'($clog2(word_bytes));
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte
//   8N1 UART byte receiver with a 2-flop synchroniser and start-bit glitch
//   rejection. The start edge is re-checked half a bit later; data and stop
//   bits are sampled at their centres.
// Ports
//   CLK        in   system clock
//   rst        in   async active-high reset (aborts a byte in flight)
//   rx         in   serial line, idle high, LSB first
//   data       out  last received byte (valid while byte_valid is high)
//   byte_valid out  one-cycle pulse, good stop bit
//   frame_err  out  one-cycle pulse, stop bit sampled low (byte dropped)
// ---------------------------------------------------------------------------
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 130
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int unsigned CW = (CLKS_PER_BIT <= 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    rx_state_t     st;
    logic          rx_meta;
    logic          rx_s;
    logic          rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    sr;

    assign data = sr;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            st         <= RX_IDLE;
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            rx_prev    <= 1'b1;
            cnt        <= '0;
            bit_idx    <= '0;
            sr         <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_s       <= rx_meta;
            rx_prev    <= rx_s;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (st)
                RX_IDLE: begin
                    // Edge, not level: a line held low after a bad stop bit
                    // must not retrigger.
                    if (rx_prev && !rx_s) begin
                        st  <= RX_START;
                        cnt <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        st      <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        sr  <= {rx_s, sr[7:1]};
                        if (bit_idx == 3'd7)
                            st <= RX_STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        st  <= RX_IDLE;
                        if (rx_s)
                            byte_valid <= 1'b1;
                        else
                            frame_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: st <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// ---------------------------------------------------------------------------
// uart_program_loader
//   Boot loader: packs UART bytes MSB-first into words. Words before the
//   DELIMITER word go to data memory, words after it to instruction memory.
//   START_EXEC ends the load.
// Ports
//   CLK         in   system clock
//   INITIALIZE  in   async active-high reset
//   UART_RX     in   serial in, 8N1, idle high
//   START_EXEC  in   end-of-load level, sampled each cycle
//   DMEM_WE     out  data-memory write strobe (one cycle per word)
//   DMEM_ADDR   out  data-memory word address
//   IMEM_WE     out  instruction-memory write strobe (one cycle per word)
//   IMEM_ADDR   out  instruction-memory word address
//   WR_DATA     out  write data shared by both ports
//   INST_COUNT  out  instructions written so far
//   LOAD_DONE   out  high from completion until reset
//   RX_ERR      out  sticky: framing error, partial word at end, overflow
//   CHECKSUM    out  only with LOADER_CHECKSUM_EN defined: modulo-2^W sum of
//                    every word written to either memory
// ---------------------------------------------------------------------------
module uart_program_loader
    import cpu_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 130,
    parameter int unsigned WORD_BYTES   = 4,
    parameter int unsigned ADDR_W       = 15,
    parameter logic [8*WORD_BYTES-1:0] DELIMITER = {(8*WORD_BYTES){DELIMITER_DEFAULT}}
) (
    input  logic                    CLK,
    input  logic                    INITIALIZE,
    input  logic                    UART_RX,
    input  logic                    START_EXEC,
    output logic                    DMEM_WE,
    output logic [ADDR_W-1:0]       DMEM_ADDR,
    output logic                    IMEM_WE,
    output logic [ADDR_W-1:0]       IMEM_ADDR,
    output logic [8*WORD_BYTES-1:0] WR_DATA,
    output logic [ADDR_W:0]         INST_COUNT,
    output logic                    LOAD_DONE,
    output logic                    RX_ERR
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [8*WORD_BYTES-1:0] CHECKSUM
`endif
);

    localparam int unsigned W   = 8 * WORD_BYTES;
    localparam int unsigned BIW = byte_idx_w(WORD_BYTES);
    localparam logic [BIW-1:0] LAST_IDX = BIW'(WORD_BYTES - 1);

    loader_state_t   state;
    logic [BIW-1:0]  byte_idx;
    logic [W-1:0]    word_sr;
    logic [W-1:0]    next_word;
    logic [ADDR_W-1:0] daddr;
    logic [ADDR_W-1:0] iaddr;
    logic            dfull;
    logic            ifull;
    logic [ADDR_W:0] inst_cnt;
    logic [7:0]      rx_byte;
    logic            rx_valid;
    logic            rx_ferr;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .CLK       (CLK),
        .rst       (INITIALIZE),
        .rx        (UART_RX),
        .data      (rx_byte),
        .byte_valid(rx_valid),
        .frame_err (rx_ferr)
    );

    always_comb begin
        next_word = (word_sr << 8) | W'(rx_byte);
    end

    assign DMEM_ADDR  = daddr;
    assign IMEM_ADDR  = iaddr;
    assign INST_COUNT = inst_cnt;
    assign LOAD_DONE  = (state == S_DONE);

    always_ff @(posedge CLK or posedge INITIALIZE) begin
        if (INITIALIZE) begin
            state    <= S_DATA;
            byte_idx <= '0;
            word_sr  <= '0;
            daddr    <= '0;
            iaddr    <= '0;
            dfull    <= 1'b0;
            ifull    <= 1'b0;
            inst_cnt <= '0;
            DMEM_WE  <= 1'b0;
            IMEM_WE  <= 1'b0;
            WR_DATA  <= '0;
            RX_ERR   <= 1'b0;
        end else begin
            DMEM_WE <= 1'b0;
            IMEM_WE <= 1'b0;

            // Addresses advance after the strobe cycle; the last address
            // latches a full flag instead of wrapping.
            if (DMEM_WE) begin
                if (daddr == '1) dfull <= 1'b1;
                else             daddr <= daddr + 1'b1;
            end
            if (IMEM_WE) begin
                inst_cnt <= inst_cnt + 1'b1;
                if (iaddr == '1) ifull <= 1'b1;
                else             iaddr <= iaddr + 1'b1;
            end

            if (state != S_DONE) begin
                if (START_EXEC) begin
                    state    <= S_DONE;
                    byte_idx <= '0;
                    if (byte_idx != '0) RX_ERR <= 1'b1;
                end else begin
                    if (rx_ferr) RX_ERR <= 1'b1;
                    if (rx_valid) begin
                        word_sr <= next_word;
                        if (byte_idx != LAST_IDX) begin
                            byte_idx <= byte_idx + 1'b1;
                        end else begin
                            byte_idx <= '0;
                            if (state == S_DATA) begin
                                if (next_word == DELIMITER) begin
                                    state <= S_INST;
                                end else if (dfull) begin
                                    RX_ERR <= 1'b1;
                                end else begin
                                    DMEM_WE <= 1'b1;
                                    WR_DATA <= next_word;
                                end
                            end else begin
                                if (ifull) begin
                                    RX_ERR <= 1'b1;
                                end else begin
                                    IMEM_WE <= 1'b1;
                                    WR_DATA <= next_word;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Strobes only occur in the load phases, so the sum freezes in S_DONE.
    always_ff @(posedge CLK or posedge INITIALIZE) begin
        if (INITIALIZE)
            CHECKSUM <= '0;
        else if (DMEM_WE || IMEM_WE)
            CHECKSUM <= CHECKSUM + WR_DATA;
    end
`endif

endmodule

// File: tb/tb_uart_program_loader.sv
module tb_uart_program_loader;

    localparam int unsigned CPB = 16;
    localparam int unsigned WB  = 4;
    localparam int unsigned AW  = 2;

    logic          CLK;
    logic          INITIALIZE;
    logic          UART_RX;
    logic          START_EXEC;
    logic          DMEM_WE;
    logic [AW-1:0] DMEM_ADDR;
    logic          IMEM_WE;
    logic [AW-1:0] IMEM_ADDR;
    logic [31:0]   WR_DATA;
    logic [AW:0]   INST_COUNT;
    logic          LOAD_DONE;
    logic          RX_ERR;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]   CHECKSUM;
`endif

    int checks   = 0;
    int failures = 0;

    uart_program_loader #(
        .CLKS_PER_BIT(CPB),
        .WORD_BYTES  (WB),
        .ADDR_W      (AW)
    ) dut (
        .CLK       (CLK),
        .INITIALIZE(INITIALIZE),
        .UART_RX   (UART_RX),
        .START_EXEC(START_EXEC),
        .DMEM_WE   (DMEM_WE),
        .DMEM_ADDR (DMEM_ADDR),
        .IMEM_WE   (IMEM_WE),
        .IMEM_ADDR (IMEM_ADDR),
        .WR_DATA   (WR_DATA),
        .INST_COUNT(INST_COUNT),
        .LOAD_DONE (LOAD_DONE),
        .RX_ERR    (RX_ERR)
`ifdef LOADER_CHECKSUM_EN
        ,
        .CHECKSUM  (CHECKSUM)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory image captured from the write ports; cleared while in reset.
    logic [31:0] dmem [4];
    logic [31:0] imem [4];
    int dwr;
    int iwr;
    int both_we;

    always @(posedge CLK) begin
        if (INITIALIZE) begin
            for (int i = 0; i < 4; i++) begin
                dmem[i] <= 32'hDEAD_BEEF;
                imem[i] <= 32'hDEAD_BEEF;
            end
            dwr     <= 0;
            iwr     <= 0;
            both_we <= 0;
        end else begin
            if (DMEM_WE) begin
                dmem[DMEM_ADDR] <= WR_DATA;
                dwr <= dwr + 1;
            end
            if (IMEM_WE) begin
                imem[IMEM_ADDR] <= WR_DATA;
                iwr <= iwr + 1;
            end
            if (DMEM_WE && IMEM_WE) both_we <= both_we + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        UART_RX    = 1'b1;
        START_EXEC = 1'b0;
        INITIALIZE = 1'b1;
        repeat (3) @(negedge CLK);
        INITIALIZE = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge CLK);
        UART_RX = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            repeat (CPB) @(negedge CLK);
        end
        UART_RX = stop;
        repeat (CPB) @(negedge CLK);
        UART_RX = 1'b1;
        repeat (CPB) @(negedge CLK);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--)
            send_byte(w[8*i +: 8], 1'b1);
        repeat (4) @(negedge CLK);
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        START_EXEC = 1'b1;
        @(negedge CLK);
        START_EXEC = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset state ----
        do_reset();
        chk("rst_dmem_we",  64'(DMEM_WE),    64'd0);
        chk("rst_imem_we",  64'(IMEM_WE),    64'd0);
        chk("rst_dmem_addr",64'(DMEM_ADDR),  64'd0);
        chk("rst_imem_addr",64'(IMEM_ADDR),  64'd0);
        chk("rst_wr_data",  64'(WR_DATA),    64'd0);
        chk("rst_inst_cnt", 64'(INST_COUNT), 64'd0);
        chk("rst_load_done",64'(LOAD_DONE),  64'd0);
        chk("rst_rx_err",   64'(RX_ERR),     64'd0);
`ifdef LOADER_CHECKSUM_EN
        chk("rst_checksum", 64'(CHECKSUM),   64'd0);
`endif

        // ---- 1: data words, delimiter, instruction, START_EXEC ----
        send_word(32'hFFFF_FFFC);
        send_word(32'hFFFF_FFFE);
        send_word(32'hFFFF_FFFF);
        send_word(32'h5C00_0000);
        @(negedge CLK);
        START_EXEC = 1'b1;
        chk("t1_done_before", 64'(LOAD_DONE), 64'd0);
        @(negedge CLK);
        START_EXEC = 1'b0;
        chk("t1_done_next",   64'(LOAD_DONE), 64'd1);
        chk("t1_dmem0",       64'(dmem[0]),   64'hFFFF_FFFC);
        chk("t1_dmem1",       64'(dmem[1]),   64'hFFFF_FFFE);
        chk("t1_imem0",       64'(imem[0]),   64'h5C00_0000);
        chk("t1_dwr",         64'(dwr),       64'd2);
        chk("t1_iwr",         64'(iwr),       64'd1);
        chk("t1_inst_cnt",    64'(INST_COUNT),64'd1);
        chk("t1_dmem_addr",   64'(DMEM_ADDR), 64'd2);
        chk("t1_rx_err",      64'(RX_ERR),    64'd0);
        chk("t1_both_we",     64'(both_we),   64'd0);

        // ---- 2: all-ones after delimiter is an instruction ----
        do_reset();
        send_word(32'hFFFF_FFFF);
        send_word(32'hFFFF_FFFF);
        chk("t2_imem0",    64'(imem[0]),    64'hFFFF_FFFF);
        chk("t2_iwr",      64'(iwr),        64'd1);
        chk("t2_dwr",      64'(dwr),        64'd0);
        send_word(32'h1122_3344);
        chk("t2_imem1",    64'(imem[1]),    64'h1122_3344);
        chk("t2_inst_cnt", 64'(INST_COUNT), 64'd2);
        chk("t2_load_done",64'(LOAD_DONE),  64'd0);

        // ---- 3: framing error drops the byte, later bytes still pack ----
        do_reset();
        send_byte(8'hAA, 1'b0);
        repeat (4) @(negedge CLK);
        chk("t3_rx_err",  64'(RX_ERR), 64'd1);
        chk("t3_no_write",64'(dwr),    64'd0);
        send_word(32'h1234_5678);
        chk("t3_dmem0",   64'(dmem[0]), 64'h1234_5678);
        chk("t3_dwr",     64'(dwr),     64'd1);

        // ---- 4: short low glitch is ignored ----
        do_reset();
        @(negedge CLK);
        UART_RX = 1'b0;
        repeat (CPB / 2 - 3) @(negedge CLK);
        UART_RX = 1'b1;
        repeat (12 * CPB) @(negedge CLK);
        chk("t4_rx_err",  64'(RX_ERR), 64'd0);
        chk("t4_no_write",64'(dwr),    64'd0);
        send_word(32'hA5C3_0F96);
        chk("t4_dmem0",   64'(dmem[0]), 64'hA5C3_0F96);
        chk("t4_dwr",     64'(dwr),     64'd1);

        // ---- 5: partial word at START_EXEC ----
        do_reset();
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        pulse_start();
        chk("t5_load_done",64'(LOAD_DONE), 64'd1);
        chk("t5_rx_err",   64'(RX_ERR),    64'd1);
        chk("t5_dwr",      64'(dwr),       64'd0);
        send_word(32'h0102_0304);
        pulse_start();
        chk("t5_dwr_after",64'(dwr),       64'd0);
        chk("t5_iwr_after",64'(iwr),       64'd0);
        chk("t5_done_hold",64'(LOAD_DONE), 64'd1);

        // ---- 6: data address overflow ----
        do_reset();
        send_word(32'hA000_0000);
        send_word(32'hA000_0001);
        send_word(32'hA000_0002);
        send_word(32'hA000_0003);
        chk("t6_full_no_err",64'(RX_ERR),   64'd0);
        chk("t6_dmem3",      64'(dmem[3]),  64'hA000_0003);
        send_word(32'hA000_0004);
        chk("t6_dwr",        64'(dwr),      64'd4);
        chk("t6_rx_err",     64'(RX_ERR),   64'd1);
        chk("t6_addr_hold",  64'(DMEM_ADDR),64'd3);
        chk("t6_dmem0",      64'(dmem[0]),  64'hA000_0000);

        // ---- 7: INITIALIZE mid-byte clears outputs and aborts the byte ----
        @(negedge CLK);
        UART_RX = 1'b0;
        repeat (3 * CPB) @(negedge CLK);
        INITIALIZE = 1'b1;
        #1;
        chk("t7_rx_err",   64'(RX_ERR),    64'd0);
        chk("t7_dmem_addr",64'(DMEM_ADDR), 64'd0);
        chk("t7_wr_data",  64'(WR_DATA),   64'd0);
        chk("t7_inst_cnt", 64'(INST_COUNT),64'd0);
        chk("t7_load_done",64'(LOAD_DONE), 64'd0);
        UART_RX = 1'b1;
        repeat (3) @(negedge CLK);
        INITIALIZE = 1'b0;
        repeat (12 * CPB) @(negedge CLK);
        send_word(32'hCAFE_F00D);
        chk("t7_dmem0",    64'(dmem[0]),   64'hCAFE_F00D);
        chk("t7_dwr",      64'(dwr),       64'd1);
        chk("t7_rx_err2",  64'(RX_ERR),    64'd0);

`ifdef LOADER_CHECKSUM_EN
        // ---- checksum wraps and excludes the delimiter ----
        do_reset();
        send_word(32'h0000_0001);
        chk("cs_first", 64'(CHECKSUM), 64'h0000_0001);
        send_word(32'hFFFF_FFFF);
        chk("cs_delim", 64'(CHECKSUM), 64'h0000_0001);
        send_word(32'hFFFF_FFFF);
        chk("cs_wrap",  64'(CHECKSUM), 64'h0000_0000);
        send_word(32'h0000_0010);
        pulse_start();
        send_word(32'h0000_0005);
        chk("cs_frozen",64'(CHECKSUM), 64'h0000_0010);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
